ahb_burst_master: RTL and testbench
===================================

// Module: ahb_burst_master
// PURPOSE
//  Synthesisable AHB-Lite master for the AHB-APB bridge subsystem. Executes
//  one command at a time: SINGLE, INCR4/8/16 or WRAP4/8/16 transfers, read or
//  write, in byte, halfword or word size. Address and data phases are pipelined.
//  Wait states (Hreadyout) and ERROR responses (Hresp) are honoured.
//  Write data is pulled from a show-ahead source. Read data is pushed out per beat.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width (32 or 64); max Hsize = clog2(DATA_W/8)
// PORTS
//  Hclk        in   1       clock; all logic on rising edge
//  Hresetn     in   1       asynchronous active-low reset
//  cmd_valid   in   1       command request
//  cmd_ready   out  1       1 only in IDLE; command accepted on valid&ready
//  cmd_write   in   1       1=write, 0=read
//  cmd_addr    in   ADDR_W  start address (must be aligned to cmd_size)
//  cmd_burst   in   3       AHB HBURST encoding; 001 (INCR) executed as SINGLE
//  cmd_size    in   3       AHB HSIZE; values above max are clamped to max
//  wr_data     in   DATA_W  write data, valid in the cycle wr_data_req=1
//  wr_data_req out  1       pop strobe for the write-data source
//  rd_data     out  DATA_W  read data (registered copy of Hrdata)
//  rd_valid    out  1       1-cycle pulse per completed read beat
//  done        out  1       1-cycle pulse when the command finishes or aborts
//  error       out  1       valid with done; 1 = aborted on ERROR response
//  Haddr       out  ADDR_W  AHB address
//  Htrans      out  2       IDLE=00, NSEQ=10, SEQ=11 (BUSY never driven)
//  Hwrite      out  1       AHB write
//  Hsize       out  3       AHB size
//  Hburst      out  3       AHB burst; echoes the command
//  Hwdata      out  DATA_W  AHB write data, registered
//  Hreadyin    out  1       0 in reset, 1 otherwise
//  Hreadyout   in   1       slave ready; phase advances only when 1
//  Hresp       in   2       00=OKAY, 01=ERROR
//  Hrdata      in   DATA_W  read data
// BEHAVIOUR
//  Reset: all outputs 0; cmd_ready=1 after reset release; state IDLE.
//  Reset mid-burst: abandon immediately; no done pulse.
//  States and transitions:
//   IDLE -> ADDR on cmd accept. Latch the command; beats = 1/4/8/16.
//   ADDR: drive NSEQ with the start address. If Hreadyout=1: go to BURST if
//    beats>1, else to LAST.
//   BURST: drive SEQ. Each accepted beat advances the address and decrements
//    beats_left. After the final address is accepted, go to LAST.
//   LAST: Htrans=IDLE. Wait for the final data phase with Hreadyout=1, then
//    pulse done and return to IDLE.
//   ERR: entered on ERROR; see below.
//  Address arithmetic, with inc = 1<<size:
//   INCR: next = addr + inc. No 1KB boundary check; the caller guarantees this.
//   WRAP: mask = beats*inc - 1; next = (addr & ~mask) | ((addr+inc) & mask).
//  Control signals (Haddr, Htrans, Hwrite, Hsize, Hburst) hold stable while
//   Hreadyout=0.
//  Write beats: wr_data_req pulses in each cycle a write address phase is
//   accepted. wr_data is registered into Hwdata in that cycle, so Hwdata is
//   valid for the whole following data phase and holds through wait states.
//  Read beats: on data-phase completion (Hreadyout=1) rd_data<=Hrdata and
//   rd_valid pulses 1 cycle later.
//  Latency: done is asserted 1 cycle after the last data phase completes.
//   A zero-wait INCR4 write runs from cmd accept to done in 6 cycles.
//  ERROR response: Hresp=01 with Hreadyout=0 is the first response cycle.
//   Next cycle: drive Htrans=IDLE, cancelling the pending beat and all
//    remaining beats.
//   On the second cycle (Hreadyout=1): pulse done with error=1, then IDLE.
//   No rd_valid and no wr_data_req for cancelled beats.
//  cmd_valid while busy: ignored (cmd_ready=0). Back-to-back commands may not
//   overlap; at least 1 cycle of IDLE separates them.
// TESTING
//  1 Write INCR4 word @0x8000_1000, 0 waits -> Haddr 1000/1004/1008/100C;
//    Htrans 10,11,11,11,00; 4 wr_data_req; done at cycle 6.
//  2 Read WRAP4 byte @0x8000_0002 -> Haddr 02/03/00/01; 4 rd_valid carrying
//    Hrdata in order; Hwrite=0.
//  3 Write WRAP8 hword @0x8000_000C with Hreadyout=0 for 2 cycles on beat 3 ->
//    Haddr wraps 0C,0E,00..0A; Haddr/Hwdata held during the stall.
//  4 Read INCR8 word, ERROR on beat 2 -> Htrans=00 the next cycle; done=1,
//    error=1; exactly 1 rd_valid.
//  5 SINGLE write and cmd_burst=001 -> one NSEQ beat each, done, error=0;
//    cmd_size=3 with DATA_W=32 -> Hsize=2.
//  6 Hresetn low mid-INCR16 -> all outputs 0 asynchronously; after release a
//    new command executes normally.

Source files
------------

// File: rtl/ahb_burst_master.sv
// ahb_burst_master: AHB-Lite master running one SINGLE/INCR/WRAP command at a time
// with pipelined address/data phases, wait states and two-cycle ERROR abort.
module ahb_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [2:0]        cmd_size,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] Haddr,
    output logic [1:0]        Htrans,
    output logic              Hwrite,
    output logic [2:0]        Hsize,
    output logic [2:0]        Hburst,
    output logic [DATA_W-1:0] Hwdata,
    output logic              Hreadyin,
    input  logic              Hreadyout,
    input  logic [1:0]        Hresp,
    input  logic [DATA_W-1:0] Hrdata
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));
    typedef enum logic [2:0] {IDLE, ADDR, BURST, LAST, ERR} state_t;
    state_t state;
    logic [4:0] cnt;
    logic dphase;
    logic accept, err_first, wrap;
    logic [2:0] size_c;
    logic [ADDR_W-1:0] inc, mask, next_addr;

    function automatic logic [4:0] beats_of(input logic [2:0] b);
        return b[2:1] == 2'b00 ? 5'd1 : 5'd2 << b[2:1];
    endfunction

    assign size_c = cmd_size > MAX_SIZE ? MAX_SIZE : cmd_size;
    assign accept = Htrans[1] & Hreadyout;
    assign err_first = dphase & (Hresp == 2'b01) & ~Hreadyout;
    assign wrap = ~Hburst[0] & |Hburst[2:1];
    assign inc = ADDR_W'(1) << Hsize;
    assign mask = (ADDR_W'(beats_of(Hburst)) << Hsize) - ADDR_W'(1);
    assign next_addr = wrap ? (Haddr & ~mask) | ((Haddr + inc) & mask) : Haddr + inc;
    assign wr_data_req = accept & Hwrite;
    assign cmd_ready = Hreadyin & (state == IDLE);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state    <= IDLE;
            cnt      <= '0;
            dphase   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            Haddr    <= '0;
            Htrans   <= 2'b00;
            Hwrite   <= 1'b0;
            Hsize    <= 3'd0;
            Hburst   <= 3'd0;
            Hwdata   <= '0;
            Hreadyin <= 1'b0;
        end else begin
            Hreadyin <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            rd_valid <= 1'b0;
            if (Hreadyout) dphase <= accept;
            if (wr_data_req) Hwdata <= wr_data;
            if (dphase & Hreadyout & ~Hwrite & (Hresp == 2'b00)) begin
                rd_data  <= Hrdata;
                rd_valid <= 1'b1;
            end
            case (state)
                IDLE: if (cmd_valid & cmd_ready) begin
                    Haddr  <= cmd_addr;
                    Htrans <= 2'b10;
                    Hwrite <= cmd_write;
                    Hsize  <= size_c;
                    Hburst <= cmd_burst;
                    cnt    <= beats_of(cmd_burst);
                    state  <= ADDR;
                end
                ADDR, BURST: if (err_first) begin
                    Htrans <= 2'b00;
                    state  <= ERR;
                end else if (Hreadyout) begin
                    // cnt counts addresses still to issue, including the one on the bus
                    if (cnt == 5'd1) begin
                        Htrans <= 2'b00;
                        state  <= LAST;
                    end else begin
                        Htrans <= 2'b11;
                        Haddr  <= next_addr;
                        cnt    <= cnt - 5'd1;
                        state  <= BURST;
                    end
                end
                LAST: if (err_first) state <= ERR;
                    else if (Hreadyout) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                ERR: if (Hreadyout) begin
                    done  <= 1'b1;
                    error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb_ahb_burst_master: directed and randomized commands checked every cycle against a
// transaction-level model (expected address lists, data-phase tracking, done timing).
module tb_ahb_burst_master;
    logic        Hclk = 1'b0, Hresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_burst = '0, cmd_size = '0;
    logic [31:0] wr_data = '0, rd_data, Haddr, Hwdata, Hrdata = '0;
    logic        wr_data_req, rd_valid, done, error, Hwrite, Hreadyin, Hreadyout = 1'b1;
    logic [1:0]  Htrans, Hresp = 2'b00;
    logic [2:0]  Hsize, Hburst;

    ahb_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
        .wr_data(wr_data), .wr_data_req(wr_data_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .error(error), .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite),
        .Hsize(Hsize), .Hburst(Hburst), .Hwdata(Hwdata), .Hreadyin(Hreadyin),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    int n_chk = 0, n_fail = 0;
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    int beats_tab[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
    logic [31:0] exp_addr[16];
    bit active = 0, cur_write = 0, dp_valid = 0, rd_exp = 0, done_exp = 0, err_exp = 0;
    bit pop = 0, rst_skip = 0, rnd_waits = 0, done_seen = 0, err_seen = 0;
    int nb = 0, ai = 0, dp_idx = 0, errstage = 0, stall_cnt = 0, cyc = 0;
    int err_at = -1, stall_at = -1, stall_len = 0;
    int rd_cnt = 0, wr_cnt = 0, acc_cyc = 0, done_cyc = 0;
    logic [2:0] cur_burst = '0, cur_size = '0, hsize_seen = '0;
    logic [31:0] rd_exp_data = '0, wexp = '0;
    logic [31:0] alog[$];

    function automatic logic [63:0] pack16(input int s);
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++)
            r = {r[47:0], (s + i < alog.size()) ? alog[s + i][15:0] : 16'hxxxx};
        return r;
    endfunction

    // Monitor, slave responder and reference model; one pass per cycle.
    initial begin
        forever begin
            bit addr_phase, acc;
            logic [31:0] total, base;
            int inc;
            @(negedge Hclk);
            #1;
            cyc++;
            if (!Hresetn) begin
                active = 0; dp_valid = 0; rd_exp = 0; done_exp = 0; errstage = 0; pop = 0;
                rst_skip = 1; Hreadyout = 1'b1; Hresp = 2'b00;
                continue;
            end
            if (rst_skip) begin
                rst_skip = 0;
                continue;
            end
            if (pop) begin
                wr_data = $urandom;
                pop = 0;
            end
            chk("cmd_ready", cmd_ready, !active);
            chk("Hreadyin", Hreadyin, 1);
            chk("rd_valid", rd_valid, rd_exp);
            if (rd_exp) chk("rd_data", rd_data, rd_exp_data);
            chk("done", done, done_exp);
            if (done_exp) chk("error", error, err_exp);
            if (rd_valid) rd_cnt++;
            if (done) begin
                done_seen = 1; err_seen = error; done_cyc = cyc;
            end
            if (dp_valid && cur_write) chk("Hwdata", Hwdata, wexp);
            rd_exp = 0; done_exp = 0;
            addr_phase = active && errstage == 0 && ai < nb;
            if (addr_phase) begin
                chk("Htrans", Htrans, ai == 0 ? 2'b10 : 2'b11);
                chk("Haddr", Haddr, exp_addr[ai]);
                chk("Hctrl", {Hwrite, Hsize, Hburst}, {cur_write, cur_size, cur_burst});
            end else chk("Htrans_idle", Htrans, 2'b00);
            Hrdata = $urandom;
            if (dp_valid && errstage == 0 && dp_idx == err_at) begin
                Hreadyout = 1'b0; Hresp = 2'b01; errstage = 1;
            end else if (errstage == 1) begin
                Hreadyout = 1'b1; Hresp = 2'b01; errstage = 2;
            end else if (dp_valid && dp_idx == stall_at && stall_cnt < stall_len) begin
                Hreadyout = 1'b0; Hresp = 2'b00; stall_cnt++;
            end else begin
                Hresp = 2'b00;
                Hreadyout = (dp_valid && rnd_waits) ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            #1;
            chk("wr_data_req", wr_data_req, addr_phase && Hreadyout && cur_write);
            if (wr_data_req) wr_cnt++;
            acc = cmd_valid && !active;
            if (dp_valid && Hreadyout) begin
                if (errstage == 2) begin
                    done_exp = 1; err_exp = 1; active = 0; errstage = 0;
                end else begin
                    if (!cur_write) begin
                        rd_exp = 1; rd_exp_data = Hrdata;
                    end
                    if (dp_idx == nb - 1) begin
                        done_exp = 1; err_exp = 0; active = 0;
                    end
                end
                dp_valid = 0;
            end
            if (addr_phase && Hreadyout) begin
                dp_valid = 1; dp_idx = ai;
                if (ai == 0) hsize_seen = Hsize;
                alog.push_back(Haddr);
                ai++;
                if (cur_write) begin
                    wexp = wr_data; pop = 1;
                end
            end
            if (acc) begin
                active = 1; ai = 0; errstage = 0; stall_cnt = 0;
                cur_write = cmd_write; cur_burst = cmd_burst;
                cur_size = cmd_size > 3'd2 ? 3'd2 : cmd_size;
                nb = beats_tab[cmd_burst];
                inc = 1 << cur_size;
                total = 32'(nb * inc);
                base = cmd_addr - cmd_addr % total;
                for (int i = 0; i < nb; i++)
                    exp_addr[i] = (cmd_burst inside {3'd2, 3'd4, 3'd6})
                        ? base + (cmd_addr - base + 32'(i * inc)) % total
                        : cmd_addr + 32'(i * inc);
                alog.delete();
                rd_cnt = 0; wr_cnt = 0; done_seen = 0; err_seen = 0; acc_cyc = cyc;
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_bus"}, {Haddr, Hwdata}, 64'h0);
        chk({tag, "_rd_data"}, rd_data, 64'h0);
        chk({tag, "_ctl"}, {cmd_ready, wr_data_req, rd_valid, done, error, Htrans, Hwrite,
                            Hsize, Hburst, Hreadyin}, 64'h0);
    endtask

    task automatic run_cmd(input bit w, input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                           input int ea, input int sa, input int sl, input bit rw, input int abort_after);
        @(negedge Hclk);
        err_at = ea; stall_at = sa; stall_len = sl; rnd_waits = rw;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_burst = b; cmd_size = s;
        @(negedge Hclk);
        cmd_write = ~w; cmd_addr = $urandom; cmd_burst = 3'($urandom);
        @(negedge Hclk);
        cmd_valid = 1'b0;
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge Hclk);
            #3 Hresetn = 1'b0;
            #1 chk_reset("abort");
            repeat (2) @(negedge Hclk);
            Hresetn = 1'b1;
            repeat (2) @(negedge Hclk);
            return;
        end
        for (int i = 0; i < 400 && active; i++) @(negedge Hclk);
        chk("cmd_timeout", active, 0);
        @(negedge Hclk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_data = $urandom;
        repeat (3) @(negedge Hclk);
        #3 chk_reset("reset");
        @(negedge Hclk);
        Hresetn = 1'b1;
        repeat (2) @(negedge Hclk);

        run_cmd(1, 32'h8000_1000, 3'b011, 3'd2, -1, -1, 0, 0, 0);
        chk("t1_len", alog.size(), 4);
        chk("t1_addr", pack16(0), 64'h1000_1004_1008_100C);
        chk("t1_wreq", wr_cnt, 4);
        chk("t1_latency", done_cyc - acc_cyc, 6);
        chk("t1_done", {done_seen, err_seen}, 2'b10);

        run_cmd(0, 32'h8000_0002, 3'b010, 3'd0, -1, -1, 0, 0, 0);
        chk("t2_addr", pack16(0), 64'h0002_0003_0000_0001);
        chk("t2_rd_cnt", rd_cnt, 4);

        run_cmd(1, 32'h8000_000C, 3'b100, 3'd1, -1, 2, 2, 0, 0);
        chk("t3_first", alog.size() > 0 ? alog[0] : 32'h0, 32'h8000_000C);
        chk("t3_addr_lo", pack16(0), 64'h000C_000E_0000_0002);
        chk("t3_addr_hi", pack16(4), 64'h0004_0006_0008_000A);
        chk("t3_latency", done_cyc - acc_cyc, 12);

        run_cmd(0, 32'h8000_0100, 3'b101, 3'd2, 1, -1, 0, 0, 0);
        chk("t4_rd_cnt", rd_cnt, 1);
        chk("t4_len", alog.size(), 2);
        chk("t4_done", {done_seen, err_seen}, 2'b11);
        chk("t4_latency", done_cyc - acc_cyc, 5);

        run_cmd(1, 32'h8000_0200, 3'b000, 3'd3, -1, -1, 0, 0, 0);
        chk("t5_single", {8'(alog.size()), 8'(wr_cnt), 5'(hsize_seen), done_seen, err_seen}, {8'd1, 8'd1, 5'd2, 2'b10});
        run_cmd(0, 32'h8000_0300, 3'b001, 3'd2, -1, -1, 0, 0, 0);
        chk("t5_incr", {8'(alog.size()), 8'(rd_cnt), done_seen, err_seen}, {8'd1, 8'd1, 2'b10});
        chk("t5_latency", done_cyc - acc_cyc, 3);

        run_cmd(1, 32'h8000_0400, 3'b111, 3'd2, -1, -1, 0, 1, 5);
        run_cmd(0, 32'h8000_0500, 3'b011, 3'd2, -1, -1, 0, 0, 0);
        chk("t6_after_reset", {8'(rd_cnt), done_seen, err_seen}, {8'd4, 2'b10});

        repeat (40) begin
            logic [2:0] b, s, sc;
            logic [31:0] a;
            int nbr, ea;
            b = 3'($urandom);
            s = 3'($urandom_range(0, 3));
            sc = s > 3'd2 ? 3'd2 : s;
            nbr = beats_tab[b];
            a = {16'h8000, 16'($urandom)} & ~((32'd1 << sc) - 32'd1);
            ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nbr - 1)) : -1;
            run_cmd(1'($urandom), a, b, s, ea, -1, 0, 1, 0);
            chk("rand_done", {done_seen, err_seen}, {1'b1, ea >= 0});
            if (ea < 0) chk("rand_len", alog.size(), nbr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
